// File: rtl/cc_pkg.sv
// Shared widths and bit positions of the 15-bit cc output vector.
package cc_pkg;
  localparam int CC_OUT_W = 15;

  localparam int A0_BIT = 14;
  localparam int F0_BIT = 13;
  localparam int G0_BIT = 12;
  localparam int I0_BIT = 11;
  localparam int J0_BIT = 10;
  localparam int K0_BIT = 9;
  localparam int L0_BIT = 8;
  localparam int M0_BIT = 7;
  localparam int N0_BIT = 6;
  localparam int O0_BIT = 5;
  localparam int P0_BIT = 4;
  localparam int W_BIT  = 3;
  localparam int X_BIT  = 2;
  localparam int Y_BIT  = 1;
  localparam int Z_BIT  = 0;

  typedef logic [CC_OUT_W-1:0] cc_out_t;
endpackage

// File: rtl/cc_fifo.sv
// Generic circular FIFO: storage, wrap-around pointers and fill level.
// Latency: a push is visible at head_dat on the next cycle; no pass-through.
// Backpressure: none internally; the caller must only push when level < DEPTH or popping.
module cc_fifo
  import cc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  W     = CC_OUT_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; stale entries are unreachable once level is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/cc_out_capture.sv
// Captures cc output samples into a FIFO, filtering repeats and counting overflow drops.
// Latency: 1 cycle from accepted sample to out_data; no combinational pass-through.
// Backpressure: in_ready low when full and not popping; new samples then dropped and counted.
module cc_out_capture
  import cc_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter int  FILTER_EN = 1,
  parameter int  CNT_W     = 8,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                clk_pad,
  input  logic                rst_n_pad,
  input  logic                in_valid,
  input  logic [CC_OUT_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [CC_OUT_W-1:0] out_data,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [LVL_W-1:0]    level
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  cc_out_t last;
  logic    have_last;
  logic    is_new;
  logic    push;
  logic    pop;
  logic    drop;

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (level < DEPTH_L) || pop;
  assign is_new    = (FILTER_EN == 0) || !have_last || (in_data != last);
  assign push      = in_valid && is_new && in_ready;
  assign drop      = in_valid && is_new && !in_ready;

  cc_fifo #(
    .DEPTH (DEPTH),
    .W     (CC_OUT_W)
  ) u_fifo (
    .clk      (clk_pad),
    .rst_n    (rst_n_pad),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (out_data),
    .level    (level)
  );

  // Only accepted samples update the filter reference; dropped ones leave it alone.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      last      <= '0;
      have_last <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        last      <= in_data;
        have_last <= 1'b1;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cc_out_capture.sv
// Bench: filtered (default) and unfiltered CNT_W=2 instances share stimulus;
// directed tables, hand sequences and a random run against a queue-style model.
module tb_cc_out_capture;
  import cc_pkg::*;

  logic          clk_pad   = 1'b0;
  logic          rst_n_pad = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [14:0]   in_data   = '0;

  logic          rdy_f, ov_f, rdy_n, ov_n;
  logic [14:0]   od_f, od_n;
  logic [7:0]    drop_f;
  logic [1:0]    drop_n;
  logic [2:0]    lvl_f, lvl_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_pad = ~clk_pad;

  cc_out_capture u_dut_f (
    .clk_pad(clk_pad), .rst_n_pad(rst_n_pad), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_f), .out_valid(ov_f), .out_data(od_f), .out_ready(out_ready),
    .drop_cnt(drop_f), .level(lvl_f)
  );

  cc_out_capture #(.DEPTH(4), .FILTER_EN(0), .CNT_W(2)) u_dut_n (
    .clk_pad(clk_pad), .rst_n_pad(rst_n_pad), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_n), .out_valid(ov_n), .out_data(od_n), .out_ready(out_ready),
    .drop_cnt(drop_n), .level(lvl_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of held samples (index 0 = oldest).
  localparam int MD = 4;
  logic [14:0] m_q [2][MD];
  int          m_n [2];
  int          m_drop [2];
  logic [14:0] m_last [2];
  bit          m_have [2];
  int          m_filt [2] = '{1, 0};
  int          m_cmax [2] = '{255, 3};

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_drop[k] = 0; m_last[k] = '0; m_have[k] = 0;
    end
  endtask

  task automatic mdl_check(input int k);
    logic        a_rdy, a_ov;
    logic [14:0] a_od;
    int          a_drop, a_lvl;
    bit          e_rdy;
    if (k == 0) begin
      a_rdy = rdy_f; a_ov = ov_f; a_od = od_f; a_drop = int'(drop_f); a_lvl = int'(lvl_f);
    end else begin
      a_rdy = rdy_n; a_ov = ov_n; a_od = od_n; a_drop = int'(drop_n); a_lvl = int'(lvl_n);
    end
    e_rdy = (m_n[k] < MD) || (m_n[k] > 0 && out_ready);
    chk($sformatf("model%0d_level", k), a_lvl, m_n[k]);
    chk($sformatf("model%0d_out_valid", k), a_ov, m_n[k] > 0);
    chk($sformatf("model%0d_in_ready", k), a_rdy, e_rdy);
    chk($sformatf("model%0d_drop_cnt", k), a_drop, m_drop[k]);
    if (m_n[k] > 0) chk($sformatf("model%0d_out_data", k), a_od, m_q[k][0]);
  endtask

  task automatic mdl_update(input int k);
    bit pop, rdy, isnew, push;
    pop   = (m_n[k] > 0) && out_ready;
    rdy   = (m_n[k] < MD) || pop;
    isnew = (m_filt[k] == 0) || !m_have[k] || (in_data != m_last[k]);
    push  = in_valid && isnew && rdy;
    if (in_valid && isnew && !rdy && m_drop[k] < m_cmax[k]) m_drop[k]++;
    if (pop) begin
      for (int i = 0; i < MD - 1; i++) m_q[k][i] = m_q[k][i+1];
      m_n[k]--;
    end
    if (push) begin
      m_q[k][m_n[k]] = in_data;
      m_n[k]++;
      m_last[k] = in_data;
      m_have[k] = 1;
    end
  endtask

  // Called at posedge+3 with inputs settled; returns at the next posedge+1.
  task automatic tick();
    mdl_check(0);
    mdl_check(1);
    @(posedge clk_pad);
    mdl_update(0);
    mdl_update(1);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n_pad = 1'b0;
    mdl_reset();
    #1;
    chk("rst_level_f", lvl_f, 0);
    chk("rst_level_n", lvl_n, 0);
    chk("rst_out_valid_f", ov_f, 0);
    chk("rst_in_ready_f", rdy_f, 1);
    chk("rst_drop_f", drop_f, 0);
    chk("rst_drop_n", drop_n, 0);
    @(posedge clk_pad);
    #1;
    rst_n_pad = 1'b1;
  endtask

  typedef struct {
    bit          iv;
    logic [14:0] d;
    bit          ordy;
    int          lvl_f;
    int          lvl_n;
    logic [14:0] head;
    bit          rdy;
    int          drp_f;
    int          drp_n;
  } vec_t;

  vec_t tab [$];

  function automatic vec_t mk(bit iv, int d, bit ordy, int lf, int ln, int hd,
                              bit rdy, int df, int dn);
    vec_t v;
    v.iv = iv; v.d = 15'(d); v.ordy = ordy; v.lvl_f = lf; v.lvl_n = ln;
    v.head = 15'(hd); v.rdy = rdy; v.drp_f = df; v.drp_n = dn;
    return v;
  endfunction

  task automatic apply_row(input int i);
    in_valid  = tab[i].iv;
    in_data   = tab[i].d;
    out_ready = tab[i].ordy;
    #2;
    chk($sformatf("row%0d_level_f", i), lvl_f, tab[i].lvl_f);
    chk($sformatf("row%0d_level_n", i), lvl_n, tab[i].lvl_n);
    chk($sformatf("row%0d_out_valid_f", i), ov_f, tab[i].lvl_f != 0);
    chk($sformatf("row%0d_in_ready", i), rdy_f, tab[i].rdy);
    chk($sformatf("row%0d_drop_f", i), drop_f, tab[i].drp_f);
    chk($sformatf("row%0d_drop_n", i), drop_n, tab[i].drp_n);
    if (tab[i].lvl_f != 0) chk($sformatf("row%0d_out_data_f", i), od_f, tab[i].head);
    if (tab[i].lvl_n != 0) chk($sformatf("row%0d_out_data_n", i), od_n, tab[i].head);
    tick();
  endtask

  initial begin
    // Repeated sample 1: filtered instance keeps one copy, unfiltered keeps all.
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 0, 1, 2, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 3, 1, 1, 0, 0));
    // Distinct 1..11 into a stalled FIFO, then a full push+pop, then hold.
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 2, 0, 1, 1, 1, 1, 0, 0));
    tab.push_back(mk(1, 3, 0, 2, 2, 1, 1, 0, 0));
    tab.push_back(mk(1, 4, 0, 3, 3, 1, 1, 0, 0));
    tab.push_back(mk(1, 5, 0, 4, 4, 1, 0, 0, 0));
    tab.push_back(mk(1, 6, 0, 4, 4, 1, 0, 1, 1));
    tab.push_back(mk(1, 7, 0, 4, 4, 1, 0, 2, 2));
    tab.push_back(mk(1, 8, 0, 4, 4, 1, 0, 3, 3));
    tab.push_back(mk(1, 9, 0, 4, 4, 1, 0, 4, 3));
    tab.push_back(mk(1, 10, 0, 4, 4, 1, 0, 5, 3));
    tab.push_back(mk(1, 11, 0, 4, 4, 1, 0, 6, 3));
    tab.push_back(mk(1, 12, 1, 4, 4, 1, 1, 7, 3));
    tab.push_back(mk(0, 0, 0, 4, 4, 2, 0, 7, 3));

    #1;
    do_reset();
    for (int i = 0; i < 4; i++) apply_row(i);
    do_reset();
    for (int i = 4; i < tab.size(); i++) apply_row(i);

    // Streaming through the pointer wrap: one push and one pop per cycle.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      in_valid  = (i < 8);
      in_data   = 15'(100 + i);
      out_ready = 1'b1;
      #2;
      if (i > 0) begin
        chk($sformatf("stream%0d_head_f", i), od_f, 100 + i - 1);
        chk($sformatf("stream%0d_head_n", i), od_n, 100 + i - 1);
        chk($sformatf("stream%0d_level_f", i), lvl_f, 1);
      end
      tick();
    end
    chk("stream_drop_f", drop_f, 0);

    // Mid-stream reset with three entries held and one drop recorded.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 15'(i * 16'h11); out_ready = 1'b0;
      #2; tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #2; tick();
    out_ready = 1'b0;
    #2;
    chk("prerst_level_f", lvl_f, 3);
    chk("prerst_drop_f", drop_f, 1);
    do_reset();
    in_valid = 1'b1; in_data = 15'h44;
    #2; tick();
    in_valid = 1'b0;
    #2;
    chk("postrst_level_f", lvl_f, 1);
    chk("postrst_head_f", od_f, 15'h44);
    tick();

    // Random traffic over a small value alphabet so the filter triggers often.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < ((c / 500) % 3) * 4 + 1);
      #2;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cc_out_capture.md
CC_OUT_CAPTURE -- requirements
Module: cc_out_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 Parameter FILTER_EN, default 1, 1 = suppress a sample equal to the last accepted sample.
REQ-003 Parameter CNT_W, default 8, width of drop_cnt.
REQ-004 clk_pad  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_pad  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  upstream sample present this cycle.
REQ-007 in_data  in  15  cc output vector; bit 14..0 = a0,f0,g0,i0,j0,k0,l0,m0,n0,o0,p0,w,x,y,z.
REQ-008 in_ready  out  1  sample can be stored this cycle.
REQ-009 out_valid  out  1  FIFO head holds a sample.
REQ-010 out_data  out  15  FIFO head sample, same bit order as in_data.
REQ-011 out_ready  in  1  downstream consumes head when out_valid=1.
REQ-012 drop_cnt  out  CNT_W  saturating count of samples lost because the FIFO was full.
REQ-013 level  out  clog2(DEPTH+1)  number of stored entries.

Function
REQ-014 pop SHALL be out_valid and out_ready; out_valid SHALL equal (level != 0).
REQ-015 in_ready SHALL equal (level < DEPTH) or pop.
REQ-016 A sample is "new" SHALL mean FILTER_EN=0, or have_last=0, or in_data != last.
REQ-017 push SHALL be in_valid and new and in_ready.
REQ-018 On push, in_data is written at wr_ptr, wr_ptr advances modulo DEPTH, last takes in_data, and have_last is set.
REQ-019 On pop, rd_ptr SHALL advance modulo DEPTH.
REQ-020 level SHALL be incremented on push only, decremented on pop only, and unchanged on both or neither.
REQ-021 Full with simultaneous push and pop: both SHALL occur, and level SHALL stay at DEPTH.
REQ-022 Empty with in_valid: out_valid stays 0 that cycle, so no pass-through; the sample appears at out_data one cycle after push (latency 1).
REQ-023 in_valid, new, and in_ready=0: sample discarded; drop_cnt increments, saturating at 2^CNT_W-1.
REQ-024 Discarded sample: last/have_last SHALL be unchanged.
REQ-025 Filtered (not new) sample: no push, no drop count, no state change.
REQ-026 out_data SHALL be mem[rd_ptr] and stable while out_valid=1 and out_ready=0.
REQ-027 out_data is don't-care when out_valid=0.

Reset
REQ-028 While rst_n_pad=0, asynchronously: wr_ptr=0, rd_ptr=0, level=0, out_valid=0, in_ready=1, drop_cnt=0, have_last=0, last=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset mid-operation SHALL discard all stored entries.
REQ-031 Reset SHALL be asserted asynchronously and released synchronously to clk_pad by the integrating level.

Structure
REQ-032 Shared package cc_pkg SHALL hold CC_OUT_W=15 and the per-bit index constants of REQ-007.
REQ-033 Sub-module cc_fifo (DEPTH, width CC_OUT_W) SHALL implement storage, pointers and level.
REQ-034 The top SHALL hold the filter, drop counter and handshake logic.

Verification
REQ-035 Reset, then in_valid=1 with 15'h0001 for 3 cycles, FILTER_EN=1, out_ready=0 -> exactly one entry stored, level=1, out_data=15'h0001 from the next cycle.
REQ-036 FILTER_EN=0, out_ready=0, 6 distinct samples 1..6 on consecutive cycles -> level=4, out_data=1, drop_cnt=2, in_ready=0.
REQ-037 Full FIFO, out_ready=1 and in_valid=1 with sample 7 in the same cycle -> head becomes 2, level stays 4, drop_cnt unchanged.
REQ-038 CNT_W=2, full FIFO, 5 further distinct samples -> drop_cnt=3 (saturated).
REQ-039 Push 8 distinct samples while draining one per cycle -> outputs in push order across the pointer wrap, no drops.
REQ-040 rst_n_pad pulsed low mid-stream with level=3 -> level=0, out_valid=0 and drop_cnt=0 immediately; a repeat of the pre-reset last value is accepted afterwards.
